// File: rtl/updown_counter_param.sv
// -----------------------------------------------------------------------------
// updown_counter_param
//
// Parametrised up/down event/timer counter with wrap or saturate behaviour at
// the count boundaries, synchronous parallel load, count enable, a registered
// one-cycle terminal-count pulse and a sticky overflow flag.
//
// Parameters
//   WIDTH    counter width in bits (2..32)
//   MAX_VAL  highest count value (1..2**WIDTH-1); count range is 0..MAX_VAL
//   RST_VAL  value of cnt after reset (<= MAX_VAL)
//
// Ports
//   clk       in   rising-edge clock
//   rest      in   asynchronous active-high reset
//   en        in   count enable, one step per cycle
//   load      in   synchronous parallel load strobe (beats en)
//   load_val  in   value to load, clamped to MAX_VAL
//   dir       in   0 = count up, 1 = count down
//   sat       in   0 = wrap at boundary, 1 = hold at boundary
//   clr_ovf   in   synchronous clear of ovf
//   cnt       out  registered count
//   tc        out  registered one-cycle terminal-count pulse
//   ovf       out  sticky boundary-event flag
//   at_zero   out  cnt == 0 (combinational decode of cnt)
//   at_max    out  cnt == MAX_VAL (combinational decode of cnt)
//
// There is no handshake: every control input is sampled on every rising
// edge, and the outputs are valid every cycle.
// -----------------------------------------------------------------------------
module updown_counter_param #(
  parameter int unsigned      WIDTH   = 4,
  parameter longint unsigned  MAX_VAL = (64'd1 << WIDTH) - 64'd1,
  parameter longint unsigned  RST_VAL = MAX_VAL
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf,
  output logic             at_zero,
  output logic             at_max
);

  // Bounds in both the count width and the one-bit-wider arithmetic width.
  localparam logic [WIDTH:0]   max_ext = MAX_VAL[WIDTH:0];
  localparam logic [WIDTH-1:0] max_cnt = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] rst_cnt = RST_VAL[WIDTH-1:0];
  localparam logic [WIDTH:0]   one_ext = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q;
  logic             tc_q;
  logic             ovf_q;

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   up_ext;
  logic [WIDTH:0]   load_ext;
  logic             up_bnd;
  logic             dn_bnd;
  logic             bnd_evt;
  logic [WIDTH-1:0] cnt_d;

  // Arithmetic is carried out one bit wider than the count so that an
  // increment from MAX_VAL = 2**WIDTH-1 is seen as exceeding the bound
  // instead of silently rolling over.
  assign cnt_ext  = {1'b0, cnt_q};
  assign up_ext   = cnt_ext + one_ext;
  assign load_ext = {1'b0, load_val};

  assign up_bnd  = (up_ext > max_ext);
  assign dn_bnd  = (cnt_q == '0);
  assign bnd_evt = en && !load && (dir ? dn_bnd : up_bnd);

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_ext > max_ext) ? max_cnt : load_val;
    end else if (en) begin
      if (dir) begin
        if (!dn_bnd)   cnt_d = cnt_q - 1'b1;
        else if (!sat) cnt_d = max_cnt;
      end else begin
        if (!up_bnd)   cnt_d = up_ext[WIDTH-1:0];
        else if (!sat) cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      cnt_q <= rst_cnt;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      // tc is a pure function of this edge's boundary event, so load and
      // hold cycles clear it automatically.
      tc_q  <= bnd_evt;
      // A boundary event on the same edge as clr_ovf keeps the flag set.
      if (bnd_evt)      ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign cnt     = cnt_q;
  assign tc      = tc_q;
  assign ovf     = ovf_q;
  assign at_zero = (cnt_q == '0);
  assign at_max  = (cnt_q == max_cnt);

endmodule

// File: tb/tb_updown_counter_param.sv
// -----------------------------------------------------------------------------
// tb_updown_counter_param
//
// Drives two counter instances with identical stimulus: instance a uses the
// default parameters (MAX 15, reset 15), instance b uses MAX 9, reset 0.
// The driver updates a behavioural model and pushes the expected outputs of
// both instances into exp_q; a monitor pops one entry after each rising edge
// and compares. Asynchronous reset is checked directly between edges.
// -----------------------------------------------------------------------------
module tb_updown_counter_param;

  localparam int W = 4;

  // clock / reset / stimulus signals
  logic         clk = 1'b0;
  logic         rest = 1'b0;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         dir = 1'b0;
  logic         sat = 1'b0;
  logic         clr_ovf = 1'b0;

  logic [W-1:0] cnt_a, cnt_b;
  logic         tc_a, tc_b, ovf_a, ovf_b;
  logic         at_zero_a, at_zero_b, at_max_a, at_max_b;

  always #5 clk = ~clk;

  updown_counter_param dut_a (
    .clk(clk), .rest(rest), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .sat(sat), .clr_ovf(clr_ovf),
    .cnt(cnt_a), .tc(tc_a), .ovf(ovf_a), .at_zero(at_zero_a), .at_max(at_max_a)
  );

  updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .RST_VAL(0)) dut_b (
    .clk(clk), .rest(rest), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .sat(sat), .clr_ovf(clr_ovf),
    .cnt(cnt_b), .tc(tc_b), .ovf(ovf_b), .at_zero(at_zero_b), .at_max(at_max_b)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: plain integers per instance.
  // ---------------------------------------------------------------------------
  int m_cnt [2];
  int m_tc  [2];
  int m_ovf [2];
  int m_max [2] = '{15, 9};
  int m_rst [2] = '{15, 0};

  // Expected entry: {a: cnt,tc,ovf,at_zero,at_max, b: same}
  logic [15:0] exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [7:0] exp_vec(int k);
    logic [7:0] v;
    v[7:4] = m_cnt[k][3:0];
    v[3]   = (m_tc[k] != 0);
    v[2]   = (m_ovf[k] != 0);
    v[1]   = (m_cnt[k] == 0);
    v[0]   = (m_cnt[k] == m_max[k]);
    return v;
  endfunction

  function automatic void model_edge(bit r, bit e, bit l, int lv, bit d, bit s, bit c);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        m_cnt[k] = m_rst[k];
        m_tc[k]  = 0;
        m_ovf[k] = 0;
      end else begin
        int lo, hi;
        bit at_edge;
        lo = 0;
        hi = m_max[k];
        if (l) begin
          m_cnt[k] = (lv > hi) ? hi : lv;
          m_tc[k]  = 0;
          if (c) m_ovf[k] = 0;
        end else if (e) begin
          at_edge = d ? (m_cnt[k] == lo) : (m_cnt[k] == hi);
          if (at_edge) begin
            if (!s) m_cnt[k] = d ? hi : lo;
            m_tc[k]  = 1;
            m_ovf[k] = 1;
          end else begin
            m_cnt[k] = d ? m_cnt[k] - 1 : m_cnt[k] + 1;
            m_tc[k]  = 0;
            if (c) m_ovf[k] = 0;
          end
        end else begin
          m_tc[k] = 0;
          if (c) m_ovf[k] = 0;
        end
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(bit r, bit e, bit l, int lv, bit d, bit s, bit c);
    @(negedge clk);
    rest     = r;
    en       = e;
    load     = l;
    load_val = lv[W-1:0];
    dir      = d;
    sat      = s;
    clr_ovf  = c;
    model_edge(r, e, l, lv, d, s, c);
    exp_q.push_back({exp_vec(0), exp_vec(1)});
  endtask

  task automatic check(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reset raised between edges; outputs must change before the next edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rest = 1'b1;
    #1;
    check("async_cnt_a", cnt_a, 15);
    check("async_tc_a",  tc_a, 0);
    check("async_ovf_a", ovf_a, 0);
    check("async_cnt_b", cnt_b, 0);
    check("async_tc_b",  tc_b, 0);
    check("async_ovf_b", ovf_b, 0);
    model_edge(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] e;
    logic [15:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {cnt_a, tc_a, ovf_a, at_zero_a, at_max_a,
               cnt_b, tc_b, ovf_b, at_zero_b, at_max_b};
        n_cmp++;
        if (act != e) begin
          n_err++;
          $display("FAIL edge_outputs: got cnt_a=%0d tc_a=%0b ovf_a=%0b z_a=%0b m_a=%0b cnt_b=%0d tc_b=%0b ovf_b=%0b z_b=%0b m_b=%0b, expected cnt_a=%0d tc_a=%0b ovf_a=%0b z_a=%0b m_a=%0b cnt_b=%0d tc_b=%0b ovf_b=%0b z_b=%0b m_b=%0b at %0t",
                   act[15:12], act[11], act[10], act[9], act[8],
                   act[7:4], act[3], act[2], act[1], act[0],
                   e[15:12], e[11], e[10], e[9], e[8],
                   e[7:4], e[3], e[2], e[1], e[0], $time);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int wait_cycles;
    #1;
    rest = 1'b1;
    #1;
    check("reset_cnt_a", cnt_a, 15);
    check("reset_tc_a",  tc_a, 0);
    check("reset_ovf_a", ovf_a, 0);
    check("reset_cnt_b", cnt_b, 0);
    check("reset_zero_b", at_zero_b, 1);
    model_edge(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // reset held across edges, then count down with wrap for 17 cycles
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 1, 0, 0);

    // reset, then count up with wrap for 12 cycles
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0, 0, 0);

    // out-of-range load clamps on b, then saturate at the top
    step(0, 0, 1, 12, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 1, 0);

    // load beats enable
    step(0, 1, 1, 5, 0, 0, 0);

    // clr_ovf on a wrapping edge keeps ovf; on a normal step clears it
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 1);
    step(0, 1, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0);

    // wrap to raise tc, then reset mid-cycle
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 0, 0);
    async_reset();
    step(1, 0, 0, 0, 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0),
           int'($urandom_range(0, 15)),
           $urandom_range(0, 1),
           $urandom_range(0, 1),
           ($urandom_range(0, 5) == 0));
    end

    // drain the scoreboard with a bounded wait
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
